// File: rtl/axi_lite_manager_if.sv
// ---------------------------------------------------------------------------
// axi_lite_manager_if
// Bundles the command/response side and the AXI4-Lite manager side of
// axi_lite_manager into one interface.
//   cmd_*  : single-transfer request (valid/ready), write flag, addr, wdata
//   rsp_*  : one-cycle completion pulse with read data, response, timeout
//   AW/W/B : AXI4-Lite write address, write data, write response channels
//   AR/R   : AXI4-Lite read address, read data channels
// Modports:
//   master : the manager (drives cmd_ready, rsp_*, AW/W/AR VALIDs, B/R READYs)
//   slave  : the environment (command source plus AXI subordinate)
// ---------------------------------------------------------------------------
interface axi_lite_manager_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // command / response
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              rsp_timeout;
  // write address / data / response
  logic                AWVALID;
  logic                AWREADY;
  logic [ADDR_W-1:0]   AWADDR;
  logic                WVALID;
  logic                WREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                BVALID;
  logic                BREADY;
  logic [1:0]          BRESP;
  // read address / data
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output AWVALID, AWADDR, input AWREADY,
    output WVALID, WDATA, WSTRB, input WREADY,
    input  BVALID, BRESP, output BREADY,
    output ARVALID, ARADDR, input ARREADY,
    input  RVALID, RDATA, RRESP, output RREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  AWVALID, AWADDR, output AWREADY,
    input  WVALID, WDATA, WSTRB, output WREADY,
    output BVALID, BRESP, input BREADY,
    input  ARVALID, ARADDR, output ARREADY,
    output RVALID, RDATA, RRESP, input RREADY
  );
endinterface

// File: rtl/axi_lite_manager.sv
// ---------------------------------------------------------------------------
// axi_lite_manager
// Single-outstanding, single-beat AXI4-Lite manager. A command accepted in
// IDLE becomes one write (AW+W, then B) or one read (AR, then R); the
// completion is reported as a one-cycle rsp_valid pulse. rsp_rdata/rsp_resp
// hold their value until the next completion.
//
// Ports:
//   ACLK    : clock, all logic on rising edge
//   ARESET  : synchronous active-high reset (abandons any transfer silently)
//   bus     : axi_lite_manager_if.master (cmd_*, rsp_*, AW/W/B/AR/R)
//
// Optional feature: define MGR_TIMEOUT_EN to build a response-wait counter.
// After TIMEOUT_CYCLES cycles in WR_RESP/RD_RESP without a handshake the
// READY drops and the transfer completes with rsp_timeout=1, rsp_resp=2'b10.
// Without the macro the manager waits for B/R indefinitely.
// ---------------------------------------------------------------------------
module axi_lite_manager #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axi_lite_manager_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              awv_q, awv_d;
  logic              wv_q, wv_d;
  logic              arv_q, arv_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;

  logic              timeout_hit;
  logic              cmd_ready_w;
  logic              bready_w, rready_w;
  logic              b_hs, r_hs;

`ifdef MGR_TIMEOUT_EN
  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_to_q, rsp_to_d;

  // Counter is cleared on entry to a RESP state, so reaching the limit
  // means TIMEOUT_CYCLES cycles of READY without a VALID.
  assign timeout_hit = ((state_q == WR_RESP) || (state_q == RD_RESP)) &&
                       (cnt_q == CNT_LIM);
  assign bus.rsp_timeout = rsp_to_q;
`else
  assign timeout_hit = 1'b0;
  // No timeout hardware in this build; the comparison is constant false for
  // any legal TIMEOUT_CYCLES and keeps the parameter list uniform.
  assign bus.rsp_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // cmd_ready is gated by ARESET so it reads 0 while reset is held and 1 in
  // the very first cycle after release (state_q is already IDLE then).
  assign cmd_ready_w = (state_q == IDLE) && !ARESET;
  assign bready_w    = (state_q == WR_RESP) && !timeout_hit;
  assign rready_w    = (state_q == RD_RESP) && !timeout_hit;
  assign b_hs        = bready_w && bus.BVALID;
  assign r_hs        = rready_w && bus.RVALID;

  // -------------------------------------------------------------------------
  // next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awv_d       = awv_q;
    wv_d        = wv_q;
    arv_d       = arv_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef MGR_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_to_d    = rsp_to_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_addr;
          if (bus.cmd_write) begin
            wdata_d = bus.cmd_wdata;
            awv_d   = 1'b1;
            wv_d    = 1'b1;
            state_d = WR_REQ;
          end else begin
            arv_d   = 1'b1;
            state_d = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        // AW and W retire independently; each VALID drops after its own
        // handshake, the response phase starts once both are gone.
        awv_d = awv_q && !bus.AWREADY;
        wv_d  = wv_q && !bus.WREADY;
        if (!awv_d && !wv_d) begin
          state_d = WR_RESP;
`ifdef MGR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      WR_RESP: begin
        if (b_hs) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bus.BRESP;
          state_d     = IDLE;
`ifdef MGR_TIMEOUT_EN
          rsp_to_d    = 1'b0;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = 2'b10;
          rsp_to_d    = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
`endif
        end
      end

      RD_REQ: begin
        if (bus.ARREADY) begin
          arv_d   = 1'b0;
          state_d = RD_RESP;
`ifdef MGR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      RD_RESP: begin
        if (r_hs) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus.RDATA;
          rsp_resp_d  = bus.RRESP;
          state_d     = IDLE;
`ifdef MGR_TIMEOUT_EN
          rsp_to_d    = 1'b0;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = 2'b10;
          rsp_to_d    = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // state registers
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      awv_q       <= 1'b0;
      wv_q        <= 1'b0;
      arv_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
`ifdef MGR_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awv_q       <= awv_d;
      wv_q        <= wv_d;
      arv_q       <= arv_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef MGR_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_to_q    <= rsp_to_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // outputs
  // -------------------------------------------------------------------------
  assign bus.cmd_ready = cmd_ready_w;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_resp  = rsp_resp_q;

  // One address register serves both AW and AR; only one transfer is ever
  // outstanding, so the two never need different values at once.
  assign bus.AWVALID = awv_q;
  assign bus.AWADDR  = addr_q;
  assign bus.WVALID  = wv_q;
  assign bus.WDATA   = wdata_q;
  assign bus.WSTRB   = '1;
  assign bus.BREADY  = bready_w;
  assign bus.ARVALID = arv_q;
  assign bus.ARADDR  = addr_q;
  assign bus.RREADY  = rready_w;

endmodule

// File: tb/tb_axi_lite_manager.sv
module tb_axi_lite_manager;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  axi_lite_manager_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_lite_manager #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // every output that must read 0 during reset, folded into one word
  function automatic logic [12:0] outs0();
    return {bus.cmd_ready, bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID,
            bus.RREADY, bus.rsp_valid, bus.rsp_timeout, bus.rsp_resp,
            |bus.rsp_rdata, |bus.AWADDR, |bus.WDATA | |bus.ARADDR};
  endfunction

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = 2'b00;
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          a_wait;   // cycles AWVALID/ARVALID held before ready
    int          w_wait;   // cycles WVALID held before WREADY
    int          r_wait;   // cycles BREADY/RREADY held before VALID
    bit          early;    // BVALID raised from the first cycle on
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    int          exp_lat;  // rsp_valid cycle relative to acceptance
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int i, input vec_t v);
    int a_c = 0, w_c = 0, r_c = 0;
    bit a_d = 0, w_d = 0, r_d = 0;
    int rsp_n = 0, rsp_k = 0, viol = 0;
    logic [31:0] rd = '0;
    logic [1:0]  rs = '0;
    logic        to = 1'b0, rdy = 1'b0;
    string n;
    n = $sformatf("v%0d", i);
    @(negedge ACLK);
    bus.cmd_valid = 1'b1; bus.cmd_write = v.wr; bus.cmd_addr = v.addr; bus.cmd_wdata = v.wdata;
    bus.RDATA = v.rdata; bus.RRESP = v.resp; bus.BRESP = v.resp;
    #1 chk({n, "_cmd_ready"}, bus.cmd_ready, 1);
    @(posedge ACLK);
    for (int k = 1; k <= 14; k++) begin
      @(negedge ACLK);
      bus.cmd_valid = 1'b0;
      if (bus.rsp_valid) begin
        rsp_n++; rsp_k = k; rd = bus.rsp_rdata; rs = bus.rsp_resp;
        to = bus.rsp_timeout; rdy = bus.cmd_ready;
      end
      if (v.wr) begin
        if (bus.ARVALID || bus.RREADY) viol++;
        if (bus.AWVALID !== !a_d) viol++;
        if (bus.AWVALID && bus.AWADDR !== v.addr) viol++;
        if (bus.WVALID !== !w_d) viol++;
        if (bus.WVALID && (bus.WDATA !== v.wdata || bus.WSTRB !== 4'hF)) viol++;
        if (bus.BREADY && !(a_d && w_d && !r_d)) viol++;
        bus.AWREADY = bus.AWVALID && (a_c >= v.a_wait);
        if (bus.AWVALID && !bus.AWREADY) a_c++;
        if (bus.AWVALID && bus.AWREADY) a_d = 1;
        bus.WREADY = bus.WVALID && (w_c >= v.w_wait);
        if (bus.WVALID && !bus.WREADY) w_c++;
        if (bus.WVALID && bus.WREADY) w_d = 1;
        bus.BVALID = !r_d && (v.early || (bus.BREADY && r_c >= v.r_wait));
        if (bus.BREADY && !bus.BVALID) r_c++;
        if (bus.BREADY && bus.BVALID) r_d = 1;
      end else begin
        if (bus.AWVALID || bus.WVALID || bus.BREADY) viol++;
        if (bus.ARVALID !== !a_d) viol++;
        if (bus.ARVALID && bus.ARADDR !== v.addr) viol++;
        if (bus.RREADY && !(a_d && !r_d)) viol++;
        bus.ARREADY = bus.ARVALID && (a_c >= v.a_wait);
        if (bus.ARVALID && !bus.ARREADY) a_c++;
        if (bus.ARVALID && bus.ARREADY) a_d = 1;
        bus.RVALID = !r_d && bus.RREADY && (r_c >= v.r_wait);
        if (bus.RREADY && !bus.RVALID) r_c++;
        if (bus.RREADY && bus.RVALID) r_d = 1;
      end
    end
    idle_inputs();
    chk({n, "_rsp_count"}, rsp_n, 1);
    chk({n, "_latency"}, rsp_k, v.exp_lat);
    chk({n, "_rdata"}, rd, v.exp_rdata);
    chk({n, "_resp"}, rs, v.resp);
    chk({n, "_timeout"}, to, 0);
    chk({n, "_ready_at_rsp"}, rdy, 1);
    chk({n, "_protocol"}, viol, 0);
    chk({n, "_rdata_hold"}, bus.rsp_rdata, v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rsp_n, brdy_n, rsp_k;
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        to;

    //        wr    addr          wdata         aw w  b  early rdata         resp   exp_rdata     lat
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0, 1'b0, 32'h0,         2'b00, 32'h0,         3};
    vecs[1] = '{1'b1, 32'h0000_0044, 32'hCAFE_F00D, 3, 0, 2, 1'b0, 32'h0,         2'b01, 32'h0,         8};
    vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,         0, 0, 4, 1'b0, 32'h1234_5678, 2'b10, 32'h1234_5678, 7};
    vecs[3] = '{1'b0, 32'h0000_0024, 32'h0,         2, 0, 1, 1'b0, 32'hA5A5_5A5A, 2'b00, 32'hA5A5_5A5A, 6};
    vecs[4] = '{1'b1, 32'h0000_0048, 32'h0BAD_CAFE, 0, 2, 0, 1'b1, 32'h0,         2'b11, 32'h0,         5};
    vecs[5] = '{1'b1, 32'h0000_004C, 32'h0000_0000, 1, 1, 0, 1'b0, 32'h0,         2'b00, 32'h0,         4};
    vecs[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         0, 0, 0, 1'b0, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFF, 3};

    // reset state
    idle_inputs();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_outputs", outs0(), 0);
    ARESET = 1'b0;
    #1 chk("reset_release_ready", bus.cmd_ready, 1);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // back-to-back: read then write with cmd_valid held throughout
    bus.AWREADY = 1'b1; bus.WREADY = 1'b1; bus.BVALID = 1'b1; bus.BRESP = 2'b00;
    bus.ARREADY = 1'b1; bus.RVALID = 1'b1; bus.RDATA = 32'h0BAD_F00D; bus.RRESP = 2'b01;
    @(negedge ACLK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h30;
    #1 chk("b2b_accept_rd", bus.cmd_ready, 1);
    @(negedge ACLK);
    chk("b2b_n1_ar_only", {bus.ARVALID, bus.AWVALID, bus.WVALID}, 3'b100);
    bus.cmd_write = 1'b1; bus.cmd_addr = 32'h34; bus.cmd_wdata = 32'h1111_2222;
    @(negedge ACLK);
    chk("b2b_n2_rready", {bus.RREADY, bus.AWVALID, bus.WVALID, bus.cmd_ready}, 4'b1000);
    @(negedge ACLK);
    chk("b2b_n3_rsp", {bus.rsp_valid, bus.cmd_ready, bus.ARVALID, bus.RREADY}, 4'b1100);
    chk("b2b_n3_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
    chk("b2b_n3_resp", bus.rsp_resp, 2'b01);
    @(negedge ACLK);
    bus.cmd_valid = 1'b0;
    chk("b2b_n4_aw_w", {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.rsp_valid}, 4'b1100);
    chk("b2b_n4_awaddr", bus.AWADDR, 32'h34);
    @(negedge ACLK);
    chk("b2b_n5_bready", {bus.BREADY, bus.AWVALID, bus.WVALID}, 3'b100);
    @(negedge ACLK);
    chk("b2b_n6_rsp", {bus.rsp_valid, bus.rsp_resp}, 3'b100);
    chk("b2b_n6_rdata", bus.rsp_rdata, 0);
    idle_inputs();
    @(negedge ACLK);
    chk("b2b_single_pulse", bus.rsp_valid, 0);

    // reset pulsed while waiting in WR_RESP; a late BVALID must be ignored
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h50; bus.cmd_wdata = 32'h55;
    bus.AWREADY = 1'b1; bus.WREADY = 1'b1;
    @(negedge ACLK);
    bus.cmd_valid = 1'b0;
    @(negedge ACLK);
    chk("rst_mid_in_wr_resp", bus.BREADY, 1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("rst_mid_outputs", outs0(), 0);
    ARESET = 1'b0;
    bus.BVALID = 1'b1; bus.BRESP = 2'b11;
    #1 chk("rst_mid_ready_after", bus.cmd_ready, 1);
    rsp_n = 0; brdy_n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      if (bus.rsp_valid) rsp_n++;
      if (bus.BREADY || !bus.cmd_ready) brdy_n++;
    end
    chk("rst_mid_no_rsp", rsp_n, 0);
    chk("rst_mid_late_b_ignored", brdy_n, 0);
    idle_inputs();

    // response never arrives
    @(negedge ACLK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h60; bus.cmd_wdata = 32'h66;
    bus.AWREADY = 1'b1; bus.WREADY = 1'b1; bus.BVALID = 1'b0;
    #1 chk("to_accept", bus.cmd_ready, 1);
    @(posedge ACLK);
    rsp_n = 0; brdy_n = 0; rsp_k = 0; rd = '1; rs = '0; to = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge ACLK);
      bus.cmd_valid = 1'b0;
      if (bus.BREADY) brdy_n++;
      if (bus.rsp_valid) begin
        rsp_n++; rsp_k = k; rd = bus.rsp_rdata; rs = bus.rsp_resp; to = bus.rsp_timeout;
      end
    end
`ifdef MGR_TIMEOUT_EN
    chk("to_rsp_count", rsp_n, 1);
    chk("to_rsp_cycle", rsp_k, 11);
    chk("to_bready_cycles", brdy_n, 8);
    chk("to_flag", to, 1);
    chk("to_resp", rs, 2'b10);
    chk("to_rdata", rd, 0);
    chk("to_back_idle", bus.cmd_ready, 1);
`else
    chk("nto_rsp_count", rsp_n, 0);
    chk("nto_bready_cycles", brdy_n, 19);
    chk("nto_stuck", {bus.cmd_ready, bus.BREADY, bus.rsp_timeout}, 3'b010);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    #1 chk("nto_recover", {bus.cmd_ready, bus.BREADY}, 2'b10);
`endif
    idle_inputs();
    repeat (2) @(negedge ACLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
